// File: rtl/conv_pkg.sv
// conv_pkg: shared types, defaults and helpers for filter-output consumers
package conv_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {IDLE, BLANK, SEARCH, DONE} stateT;

    // |x| with the most negative value clamped to the largest positive value
    function automatic logic [DATA_W_DEFAULT-1:0] absSat(input logic signed [DATA_W_DEFAULT-1:0] x);
        return x == {1'b1, {(DATA_W_DEFAULT-1){1'b0}}} ? {1'b0, {(DATA_W_DEFAULT-1){1'b1}}} :
               x[DATA_W_DEFAULT-1] ? -x : x;
    endfunction

endpackage

// File: rtl/conv_abs_sat.sv
// conv_abs_sat: combinational signed-to-unsigned magnitude with saturation
module conv_abs_sat
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic signed [DATA_W-1:0] iData,
    output logic        [DATA_W-1:0] oMag
);

    localparam logic [DATA_W-1:0] minNeg = {1'b1, {(DATA_W-1){1'b0}}};

    // negate negatives; -2^(W-1) has no positive twin so it clamps
    always_comb begin
        oMag = iData == minNeg ? ~minNeg : iData[DATA_W-1] ? -iData : iData;
    end

endmodule

// File: rtl/conv_peak_detector.sv
// conv_peak_detector: blanked, windowed largest-magnitude search on the FIR output
module conv_peak_detector
    import conv_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int BLANK_LEN  = 64,
    parameter int WINDOW_LEN = 4096,
    parameter int IDX_W      = 13
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     iStart,
    input  logic signed [DATA_W-1:0] iData,
    input  logic                     iDataValid,
    input  logic        [DATA_W-1:0] iThreshold,
    input  logic                     iResultAck,
    output logic        [DATA_W-1:0] oPeakVal,
    output logic        [IDX_W-1:0]  oPeakIdx,
    output logic                     oDetected,
    output logic                     oResultValid,
    output logic                     oBusy
);

    localparam logic [IDX_W-1:0] blankLast  = IDX_W'(BLANK_LEN - 1);
    localparam logic [IDX_W-1:0] windowLast = IDX_W'(BLANK_LEN + WINDOW_LEN - 1);
    localparam stateT            firstState = BLANK_LEN == 0 ? SEARCH : BLANK;

    stateT             state, nextState;
    logic [IDX_W-1:0]  cnt, runIdx, newIdx;
    logic [DATA_W-1:0] runPeak, newPeak, thrLatch, mag;
    logic              startAccept, searchValid, isUpdate;

    conv_abs_sat #(.DATA_W(DATA_W)) uAbs (.iData(iData), .oMag(mag));

    // running peak including the current sample; ties keep the earlier one
    always_comb begin
        startAccept = iStart && (state == IDLE || (state == DONE && iResultAck));
        searchValid = state == SEARCH && iDataValid;
        isUpdate    = mag > runPeak;
        newPeak     = isUpdate ? mag : runPeak;
        newIdx      = isUpdate ? cnt : runIdx;
    end

    // state register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // next-state: captures never restart mid-window, only from IDLE or an acked DONE
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = iStart ? firstState : IDLE;
            BLANK:   nextState = iDataValid && cnt == blankLast ? SEARCH : BLANK;
            SEARCH:  nextState = iDataValid && cnt == windowLast ? DONE : SEARCH;
            DONE:    nextState = iResultAck ? (iStart ? firstState : IDLE) : DONE;
            default: nextState = IDLE;
        endcase
    end

    // busy decode from the registered state
    always_comb begin
        oBusy = state == BLANK || state == SEARCH;
    end

    // datapath: counter, running peak, threshold latch and held result registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            runPeak      <= '0;
            runIdx       <= '0;
            thrLatch     <= '0;
            oPeakVal     <= '0;
            oPeakIdx     <= '0;
            oDetected    <= 1'b0;
            oResultValid <= 1'b0;
        end else begin
            if (startAccept) begin
                cnt      <= '0;
                runPeak  <= '0;
                runIdx   <= '0;
                thrLatch <= iThreshold;
            end else if ((state == BLANK && iDataValid) || searchValid) begin
                cnt <= cnt + 1'b1;
            end
            if (searchValid) begin
                runPeak <= newPeak;
                runIdx  <= newIdx;
            end
            if (searchValid && cnt == windowLast) begin
                oPeakVal     <= newPeak;
                oPeakIdx     <= newIdx;
                oDetected    <= newPeak >= thrLatch;
                oResultValid <= 1'b1;
            end else if (state == DONE && iResultAck) begin
                oResultValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_peak_detector.sv
// tb_conv_peak_detector: directed checks of blanking, peak search, saturation and handshake
module tb_conv_peak_detector;

    logic               CLK, reset, iStart, iDataValid, iResultAck;
    logic signed [31:0] iData;
    logic        [31:0] iThreshold, oPeakVal;
    logic        [12:0] oPeakIdx;
    logic               oDetected, oResultValid, oBusy;
    logic signed [31:0] smp [20];
    int                 checks = 0;
    int                 failures = 0;

    conv_peak_detector #(.DATA_W(32), .BLANK_LEN(4), .WINDOW_LEN(16), .IDX_W(13)) dut (
        .CLK(CLK), .reset(reset), .iStart(iStart), .iData(iData), .iDataValid(iDataValid),
        .iThreshold(iThreshold), .iResultAck(iResultAck), .oPeakVal(oPeakVal), .oPeakIdx(oPeakIdx),
        .oDetected(oDetected), .oResultValid(oResultValid), .oBusy(oBusy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic signed [31:0] v);
        for (int i = 0; i < 20; i++) smp[i] = v;
    endtask

    task automatic startCap(input logic [31:0] thr);
        iStart = 1'b1;
        iThreshold = thr;
        cyc();
        iStart = 1'b0;
    endtask

    task automatic feed(input bit gaps);
        for (int i = 0; i < 20; i++) begin
            iData = smp[i];
            iDataValid = 1'b1;
            cyc();
            if (i == 18) begin
                chk("pre_last_valid", oResultValid, 0);
                chk("pre_last_busy", oBusy, 1);
            end
            if (gaps && i < 19) begin
                iDataValid = 1'b0;
                iData = 32'sh7fff_0000;
                iStart = 1'b1;
                iThreshold = 32'hffff_ffff;
                cyc();
                iStart = 1'b0;
            end
        end
        iDataValid = 1'b0;
        iData = '0;
    endtask

    task automatic chkRes(input string tag, input logic [31:0] v, input logic [12:0] idx, input logic det);
        chk({tag, "_valid"}, oResultValid, 1);
        chk({tag, "_val"}, oPeakVal, v);
        chk({tag, "_idx"}, oPeakIdx, idx);
        chk({tag, "_det"}, oDetected, det);
        chk({tag, "_busy"}, oBusy, 0);
    endtask

    task automatic ack();
        iResultAck = 1'b1;
        cyc();
        iResultAck = 1'b0;
        chk("ack_valid", oResultValid, 0);
        chk("ack_busy", oBusy, 0);
    endtask

    initial begin
        reset = 1'b0;
        iStart = 1'b0;
        iData = '0;
        iDataValid = 1'b0;
        iThreshold = '0;
        iResultAck = 1'b0;
        repeat (2) cyc();
        chk("rst_val", oPeakVal, 0);
        chk("rst_idx", oPeakIdx, 0);
        chk("rst_det", oDetected, 0);
        chk("rst_valid", oResultValid, 0);
        chk("rst_busy", oBusy, 0);
        reset = 1'b1;
        cyc();

        fill(10);
        smp[9] = 500;
        startCap(100);
        chk("start_busy", oBusy, 1);
        feed(0);
        chkRes("basic", 500, 9, 1);
        repeat (10) cyc();
        chkRes("hold", 500, 9, 1);
        ack();
        chk("kept_val", oPeakVal, 500);
        chk("kept_idx", oPeakIdx, 9);

        startCap(0);
        for (int i = 0; i < 8; i++) begin
            iData = 32'sd1234;
            iDataValid = 1'b1;
            cyc();
        end
        reset = 1'b0;
        #2;
        chk("abort_val", oPeakVal, 0);
        chk("abort_idx", oPeakIdx, 0);
        chk("abort_det", oDetected, 0);
        chk("abort_valid", oResultValid, 0);
        chk("abort_busy", oBusy, 0);
        iDataValid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        fill(10);
        smp[2] = 9000;
        smp[6] = -700;
        smp[12] = 700;
        startCap(1000);
        feed(0);
        chkRes("tie", 700, 6, 0);
        ack();

        fill(10);
        smp[5] = 32'sh8000_0000;
        startCap(32'h7fff_ffff);
        feed(0);
        chkRes("sat", 32'h7fff_ffff, 5, 1);
        ack();

        fill(50);
        startCap(100);
        feed(0);
        chkRes("flat", 50, 4, 0);
        ack();

        fill(10);
        smp[9] = 500;
        startCap(100);
        feed(1);
        chkRes("gaps", 500, 9, 1);
        ack();

        fill(10);
        smp[19] = 800;
        startCap(900);
        feed(0);
        chkRes("last", 800, 19, 0);
        iResultAck = 1'b1;
        iStart = 1'b1;
        iThreshold = 0;
        cyc();
        iResultAck = 1'b0;
        iStart = 1'b0;
        chk("ackstart_valid", oResultValid, 0);
        chk("ackstart_busy", oBusy, 1);
        chk("ackstart_kept", oPeakVal, 800);
        fill(0);
        feed(0);
        chkRes("zero", 0, 0, 1);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
